// File: rtl/fcvt_pkg.sv
// Shared types and defaults for the int<->float conversion scheduler.
package fcvt_pkg;

  typedef enum logic {
    FCVT_ITOF = 1'b0,
    FCVT_FTOI = 1'b1
  } fcvt_op_t;

  localparam int FCVT_TAG_W = 5;

  // Tag width is a module parameter, so the S1 tag is registered beside this struct.
  typedef struct packed {
    fcvt_op_t    op;
    logic [31:0] x;
    logic        id;
  } fcvt_s1_t;

endpackage

// File: rtl/fcvt_core.sv
// Combinational conversion core: itof/ftoi selected by op.
// Optional ftoi overflow flag under FCVT_SCHED_OVF_EN; otherwise ovf is tied 0.
module fcvt_core
  import fcvt_pkg::*;
(
  input  fcvt_op_t    op,
  input  logic [31:0] x,
  output logic [31:0] y,
  output logic        ovf
);

  logic [31:0] y_itof;
  logic [31:0] y_ftoi;

  itof u_itof (.x(x), .y(y_itof));
  ftoi u_ftoi (.x(x), .y(y_ftoi));

  assign y = (op == FCVT_FTOI) ? y_ftoi : y_itof;

`ifdef FCVT_SCHED_OVF_EN
  // -2^31 is the one exactly representable value at the overflow exponent.
  assign ovf = (op == FCVT_FTOI) && (x[30:23] >= 8'd158) && (x != 32'hCF00_0000);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/ftoi.sv
// Float32 to signed int32 conversion, truncating toward zero and saturating.
module ftoi (
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [7:0]  e;
  logic [4:0]  sh;
  logic [31:0] mag;

  always_comb begin
    e   = x[30:23];
    sh  = 5'(e - 8'd127);
    mag = 32'(({31'd0, 1'b1, x[22:0]} << sh) >> 23);
    y   = 32'd0;
    if (e >= 8'd158) begin
      // NaN saturates positive; infinities and large values keep their sign.
      if (x[31] && !((e == 8'hFF) && (x[22:0] != 23'd0))) y = 32'h8000_0000;
      else                                               y = 32'h7FFF_FFFF;
    end else if (e >= 8'd127) begin
      y = x[31] ? (~mag + 32'd1) : mag;
    end
  end

endmodule

// File: rtl/itof.sv
// Signed int32 to float32 conversion, round-to-nearest-even.
module itof (
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic        sign;
  logic [31:0] mag;
  logic [4:0]  msb;
  logic [30:0] norm;
  logic [7:0]  exp_b;
  logic        rnd;

  always_comb begin
    sign = x[31];
    mag  = sign ? (~x + 32'd1) : x;
    msb  = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    // Leading one shifted out of the top; [30:8] mantissa, [7] guard, [6:0] sticky.
    norm  = 31'(mag << (5'd31 - msb));
    exp_b = 8'd127 + {3'b000, msb};
    rnd   = norm[7] & ((|norm[6:0]) | norm[8]);
    if (mag == 32'd0) y = 32'd0;
    else              y = {sign, ({exp_b, norm[30:8]} + {30'd0, rnd})};
  end

endmodule

// File: rtl/fcvt_sched.sv
// Round-robin scheduler for the shared int<->float converter: two requesters,
// S1/S2 pipeline, flush. Optional ftoi overflow flag: FCVT_SCHED_OVF_EN.
module fcvt_sched
  import fcvt_pkg::*;
#(
  parameter int TAG_W = FCVT_TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_x0,
  input  logic [31:0]      req_x1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_id,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  logic             s1_valid_reg;
  fcvt_s1_t         s1_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic             s2_valid_reg;
  logic [31:0]      s2_y_reg;
  logic             s2_id_reg;
  logic [TAG_W-1:0] s2_tag_reg;
  logic             s2_ovf_reg;
  logic             rr_ptr_reg;

  logic             s2_load;
  logic             s1_free;
  logic             grant_any;
  logic             grant_id;
  logic             accept;
  fcvt_s1_t         s1_next;
  logic [TAG_W-1:0] tag_next;
  logic [31:0]      core_y;
  logic             core_ovf;

  assign s2_load = !s2_valid_reg || out_ready;
  assign s1_free = !s1_valid_reg || s2_load;

  always_comb begin
    grant_any = |req_valid;
    grant_id  = rr_ptr_reg;
    if (req_valid != 2'b11) grant_id = req_valid[1];
  end

  // Ready is forced low while in reset so nothing looks accepted.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = rstn && grant_any && (grant_id == 1'(gi)) && s1_free && !flush;
  end

  assign accept = |req_ready;

  always_comb begin
    s1_next    = '0;
    s1_next.op = fcvt_op_t'(req_op[grant_id]);
    s1_next.x  = grant_id ? req_x1 : req_x0;
    s1_next.id = grant_id;
    tag_next   = grant_id ? req_tag1 : req_tag0;
  end

  fcvt_core u_core (
    .op  (s1_reg.op),
    .x   (s1_reg.x),
    .y   (core_y),
    .ovf (core_ovf)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_reg <= 1'b0;
      s1_reg       <= '0;
      s1_tag_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_y_reg     <= '0;
      s2_id_reg    <= 1'b0;
      s2_tag_reg   <= '0;
      s2_ovf_reg   <= 1'b0;
      rr_ptr_reg   <= 1'b0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_y_reg   <= core_y;
          s2_id_reg  <= s1_reg.id;
          s2_tag_reg <= s1_tag_reg;
          s2_ovf_reg <= core_ovf;
        end
      end
      if (accept) begin
        s1_valid_reg <= 1'b1;
        s1_reg       <= s1_next;
        s1_tag_reg   <= tag_next;
        rr_ptr_reg   <= ~grant_id;
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_y     = s2_y_reg;
  assign out_id    = s2_id_reg;
  assign out_tag   = s2_tag_reg;
  assign out_ovf   = s2_ovf_reg;

endmodule

// File: tb/tb_fcvt_sched.sv
// Self-checking bench for fcvt_sched: per-cycle behavioural model plus directed
// vectors with hand-computed results. Honours FCVT_SCHED_OVF_EN if defined.
module tb_fcvt_sched;
  import fcvt_pkg::*;

  localparam int TW = 5;
`ifdef FCVT_SCHED_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk;
  logic          rstn;
  logic          flush;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_op;
  logic [31:0]   req_x0;
  logic [31:0]   req_x1;
  logic [TW-1:0] req_tag0;
  logic [TW-1:0] req_tag1;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_y;
  logic          out_id;
  logic [TW-1:0] out_tag;
  logic          out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  fcvt_sched #(.TAG_W(TW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x0    (req_x0),
    .req_x1    (req_x1),
    .req_tag0  (req_tag0),
    .req_tag1  (req_tag1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversions through the simulator's real arithmetic.
  function automatic logic [31:0] m_itof(input logic [31:0] x);
    logic [63:0] d;
    logic        up;
    int          e;
    if (x == 32'd0) return 32'd0;
    d  = $realtobits($itor($signed(x)));
    e  = int'(d[62:52]) - 1023 + 127;
    up = (d[28:0] > 29'h1000_0000) || ((d[28:0] == 29'h1000_0000) && d[29]);
    return {d[63], 31'({e[7:0], d[51:29]}) + 31'(up)};
  endfunction

  function automatic logic [31:0] m_ftoi(input logic [31:0] f);
    logic [10:0] de;
    real         r;
    if ((f[30:23] == 8'hFF) && (f[22:0] != 23'd0)) return 32'h7FFF_FFFF;
    if (f[30:23] == 8'd0) return 32'd0;
    de = 11'(int'(f[30:23]) - 127 + 1023);
    r  = $bitstoreal({f[31], de, f[22:0], 29'd0});
    if (r >= 2147483648.0) return 32'h7FFF_FFFF;
    if (r <= -2147483648.0) return 32'h8000_0000;
    return 32'($rtoi(r));
  endfunction

  function automatic logic m_ovf(input logic op, input logic [31:0] f);
    return OVF_EN && op && (f[30:23] >= 8'd158) && (f != 32'hCF00_0000);
  endfunction

  typedef struct {
    logic [31:0]   y;
    logic          id;
    logic [TW-1:0] tag;
    logic          ovf;
    int            age;
  } ent_t;

  typedef struct {
    logic [31:0]   y;
    logic          id;
    logic [TW-1:0] tag;
    logic          ovf;
  } res_t;

  ent_t        q[$];
  res_t        log_q[$];
  ent_t        m_e;
  logic        m_rr;
  logic        m_ov;
  logic        m_gid;
  logic        m_can;
  logic [1:0]  m_rdy;
  logic [31:0] m_x;
  logic        m_op;

  // Model: in-flight results in order, each visible once two cycles old and at the head.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_y", out_y, 32'd0);
      chk("rst_out_id", 32'(out_id), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      q.delete();
      m_rr = 1'b0;
    end else begin
      m_ov = (q.size() > 0) && (q[0].age >= 2);
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("out_y", out_y, q[0].y);
        chk("out_id", 32'(out_id), 32'(q[0].id));
        chk("out_tag", 32'(out_tag), 32'(q[0].tag));
        chk("out_ovf", 32'(out_ovf), 32'(q[0].ovf));
      end
      m_gid = (req_valid == 2'b11) ? m_rr : req_valid[1];
      m_can = (q.size() < 2) || out_ready;
      m_rdy = 2'b00;
      if ((req_valid != 2'b00) && m_can && !flush) m_rdy[m_gid] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(m_rdy));
      if (out_valid && out_ready && !flush)
        log_q.push_back('{y: out_y, id: out_id, tag: out_tag, ovf: out_ovf});
      if (flush) begin
        q.delete();
      end else begin
        if (m_ov && out_ready) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (m_rdy != 2'b00) begin
          m_x      = m_gid ? req_x1 : req_x0;
          m_op     = req_op[m_gid];
          m_e.y    = m_op ? m_ftoi(m_x) : m_itof(m_x);
          m_e.id   = m_gid;
          m_e.tag  = m_gid ? req_tag1 : req_tag0;
          m_e.ovf  = m_ovf(m_op, m_x);
          m_e.age  = 1;
          q.push_back(m_e);
          m_rr = ~m_gid;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input logic id, input logic op, input logic [31:0] x, input logic [TW-1:0] tag);
    bit hs = 1'b0;
    if (id) begin
      req_x1   = x;
      req_tag1 = tag;
    end else begin
      req_x0   = x;
      req_tag0 = tag;
    end
    req_op[id]    = op;
    req_valid[id] = 1'b1;
    for (int c = 0; c < 20 && !hs; c++) begin
      #2;
      hs = req_ready[id];
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
    chk("send_handshake", 32'(hs), 32'd1);
  endtask

  logic [31:0] tv_x[15];
  logic [31:0] tv_y[15];
  bit          tv_op[15];
  bit          tv_ovf[15];

  initial begin
    tv_op  = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    tv_x   = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0100_0001, 32'h0100_0003, 32'h4F00_0000,
               32'hCF00_0000, 32'h3FC0_0000, 32'hBFC0_0000, 32'h7F80_0000, 32'hFF80_0000,
               32'h7FC0_0000, 32'h3F00_0000, 32'h4EFF_FFFF, 32'hCF00_0001, 32'h0000_0000};
    tv_y   = '{32'hCF00_0000, 32'h4F00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h7FFF_FFFF,
               32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
               32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FF80, 32'h8000_0000, 32'h0000_0000};
    tv_ovf = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0};

    rstn = 1'b1; flush = 1'b0; req_valid = 2'b00; req_op = 2'b00;
    req_x0 = '0; req_x1 = '0; req_tag0 = '0; req_tag1 = '0; out_ready = 1'b1;
    #1 rstn = 1'b0;
    @(posedge clk); #1;
    step(1);
    rstn = 1'b1;

    // Both requesters valid every cycle: grants alternate starting at 0.
    log_q.delete();
    req_op = 2'b10; req_x0 = 32'hFFFF_FFFF; req_x1 = 32'h4040_0000;
    req_tag0 = 5'd1; req_tag1 = 5'd2; req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1 chk("alt_ready", 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      step(1);
    end
    req_valid = 2'b00;
    step(4);
    chk("alt_count", log_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("alt_id", 32'(log_q[i].id), 32'(i % 2));
      chk("alt_y", log_q[i].y, (i % 2 == 0) ? 32'hBF80_0000 : 32'h0000_0003);
      chk("alt_tag", 32'(log_q[i].tag), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Single itof with two-cycle latency.
    log_q.delete();
    send(1'b0, 1'b0, 32'h0000_0001, 5'd3);
    #1 chk("lat_k1_valid", 32'(out_valid), 32'd0);
    step(1);
    #1 chk("lat_k2_valid", 32'(out_valid), 32'd1);
    step(2);
    chk("single_count", log_q.size(), 32'd1);
    if (log_q.size() > 0) begin
      chk("single_y", log_q[0].y, 32'h3F80_0000);
      chk("single_id", 32'(log_q[0].id), 32'd0);
      chk("single_tag", 32'(log_q[0].tag), 32'd3);
      chk("single_ovf", 32'(log_q[0].ovf), 32'd0);
    end

    // Conversion corner vectors, streamed back to back.
    log_q.delete();
    for (int i = 0; i < 15; i++) begin
      chk("model_pin", tv_op[i] ? m_ftoi(tv_x[i]) : m_itof(tv_x[i]), tv_y[i]);
      send(1'(i % 2), tv_op[i], tv_x[i], 5'(i));
    end
    step(4);
    chk("vec_count", log_q.size(), 32'd15);
    for (int i = 0; i < 15 && i < log_q.size(); i++) begin
      chk("vec_y", log_q[i].y, tv_y[i]);
      chk("vec_ovf", 32'(log_q[i].ovf), 32'(OVF_EN && tv_ovf[i]));
      chk("vec_tag", 32'(log_q[i].tag), 32'(i));
    end

    // Output stall with three requests queued.
    log_q.delete();
    fork
      begin
        send(1'b0, 1'b0, 32'd5, 5'd10);
        send(1'b0, 1'b0, 32'hFFFF_FFFE, 5'd11);
        send(1'b0, 1'b1, 32'h4120_0000, 5'd12);
      end
      begin
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          if (c >= 2) begin
            #2;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_y", out_y, 32'h40A0_0000);
            chk("stall_tag", 32'(out_tag), 32'd10);
            chk("stall_ready", 32'(req_ready), 32'd0);
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    step(4);
    chk("stall_count", log_q.size(), 32'd3);
    if (log_q.size() == 3) begin
      chk("stall_r1", log_q[0].y, 32'h40A0_0000);
      chk("stall_r2", log_q[1].y, 32'hC000_0000);
      chk("stall_r3", log_q[2].y, 32'h0000_000A);
    end

    // Flush with S1 and S2 occupied.
    log_q.delete();
    out_ready = 1'b0;
    send(1'b0, 1'b0, 32'd7, 5'd1);
    send(1'b0, 1'b0, 32'd9, 5'd2);
    flush = 1'b1; out_ready = 1'b1;
    req_op[1] = 1'b0; req_x1 = 32'd11; req_tag1 = 5'd3; req_valid = 2'b10;
    #1 chk("flush_pre_valid", 32'(out_valid), 32'd1);
    chk("flush_no_accept", 32'(req_ready), 32'd0);
    step(1);
    flush = 1'b0;
    #1 chk("flush_cleared", 32'(out_valid), 32'd0);
    chk("post_flush_ready", 32'(req_ready), 32'd2);
    step(1);
    req_valid = 2'b00;
    #1 chk("post_flush_k1", 32'(out_valid), 32'd0);
    step(1);
    #1 chk("post_flush_k2", 32'(out_valid), 32'd1);
    chk("post_flush_y", out_y, 32'h4130_0000);
    chk("post_flush_id", 32'(out_id), 32'd1);
    step(2);
    chk("flush_count", log_q.size(), 32'd1);

    // Reset while a result is held on the output.
    out_ready = 1'b0;
    send(1'b1, 1'b0, 32'd5, 5'd4);
    send(1'b0, 1'b0, 32'd6, 5'd5);
    #1 chk("pre_rst_valid", 32'(out_valid), 32'd1);
    req_x0 = 32'd1; req_x1 = 32'd2; req_op = 2'b00; req_valid = 2'b11;
    rstn = 1'b0;
    #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_y", out_y, 32'd0);
    chk("async_rst_id", 32'(out_id), 32'd0);
    chk("async_rst_tag", 32'(out_tag), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    step(2);
    rstn = 1'b1; out_ready = 1'b1;
    #1 chk("first_grant", 32'(req_ready), 32'd1);
    step(1);
    req_valid = 2'b00;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fcvt_sched.md
# fcvt_sched

Sequencer and arbiter for the shared int↔float conversion datapath (`itof`, `ftoi`). Two issue ports (integer pipe, FP pipe) compete for one conversion unit. The block grants one request per cycle round-robin, runs it through a two-register pipeline, and returns the result tagged with requester id and destination tag under valid/ready backpressure. It sits between the issue stage and the FP writeback arbiter.

## Interface
- `TAG_W`, default 5: destination tag width.
- `clk` input, 1: clock, rising edge.
- `rstn` input, 1: asynchronous reset, active low.
- `flush` input, 1: synchronous kill of every in-flight and presented request.
- `req_valid` input, 2: request valid, index = requester id.
- `req_ready` output, 2: request accepted when `req_valid[i] && req_ready[i]`.
- `req_op` input, 2: per requester; 0 = itof (int32→float32), 1 = ftoi (float32→int32).
- `req_x0`, `req_x1` input, 32: operand per requester.
- `req_tag0`, `req_tag1` input, TAG_W: destination tag per requester.
- `out_valid` output, 1: result valid.
- `out_ready` input, 1: consumer accepts result.
- `out_y` output, 32: conversion result.
- `out_id` output, 1: requester id of the result.
- `out_tag` output, TAG_W: tag of the result.
- `out_ovf` output, 1: ftoi overflow flag (see Configuration).

## Operation
- Stage S1 register: valid, op, x, id, tag. Stage S2 (output) register: valid, y, id, tag, ovf.
- S2 loads when `!out_valid || out_ready`. S1 can accept when S1 is empty or S1 advances into S2 in the same cycle.
- Arbitration: `rr_ptr` points to the preferred requester. If both are valid, grant `rr_ptr`. If only one is valid, grant that one. After any accepted grant, `rr_ptr` ← ~granted id. Reset value of `rr_ptr` is 0.
- `req_ready[i]` = granted(i) && S1 can accept && !flush. It is combinational from `req_valid`, `rr_ptr` and pipeline state. At most one bit is set per cycle. A non-granted requester sees ready = 0.
- Conversion is combinational from S1, through the sub-module, into S2. `ftoi` truncation and rounding behaviour is inherited unchanged from the existing unit. Results must bit-match standalone `itof`/`ftoi`.
- `flush`: at the next edge S1.valid ← 0 and S2.valid ← 0. No request is accepted in a flush cycle. `rr_ptr` is unchanged.
- Stall: while `out_valid && !out_ready`, S2 holds its contents stable. S1 holds if occupied. `req_ready` = 0 when S1 is full and cannot advance.
- Reset (async, `rstn` = 0): S1.valid = 0, S2.valid = 0, `rr_ptr` = 0. Outputs read `out_valid` = 0, `out_y` = 0, `out_id` = 0, `out_tag` = 0, `out_ovf` = 0, `req_ready` = 0. Reset mid-operation discards all in-flight work.

## Timing
- Latency: a request accepted in cycle k gives `out_valid` = 1 in cycle k+2, provided there is no stall.
- Throughput: one conversion per cycle while `out_ready` = 1. Back-to-back grants alternate when both requesters are continuously valid.
- `out_*` are registered. `req_ready` is combinational (no combinational path from `out_ready` to `out_*`).
- Simultaneous `flush` and `out_ready`: flush wins, and the result is dropped (consumer must ignore the handshake in that cycle).

## Configuration
- `FCVT_SCHED_OVF_EN` defined: the S2 stage computes `out_ovf` for ftoi ops. The flag is 1 when the biased exponent ≥ 158 (|x| ≥ 2^31, including Inf/NaN), except for exactly 0xCF000000 (−2^31), which gives 0. itof ops always give 0.
- `FCVT_SCHED_OVF_EN` undefined: the port still exists, tied to 0, and no overflow logic is synthesized.

## Structure
- Package `fcvt_pkg`:
  - `fcvt_op_t` enum (FCVT_ITOF = 0, FCVT_FTOI = 1).
  - Default `TAG_W`.
  - Struct `fcvt_s1_t` for the S1 payload.
- Sub-module `fcvt_core`: instantiates `itof` and `ftoi`, muxes by op, and produces y and ovf. It is purely combinational.
- Arbiter, pipeline registers and flush logic live in `fcvt_sched`.

## Test plan
- Requester 0, itof, x = 0x00000001, tag 3 → two cycles later `out_y` = 0x3F800000, `out_id` = 0, `out_tag` = 3, `out_ovf` = 0.
- Both valid every cycle (req0 itof 0xFFFFFFFF, req1 ftoi 0x40400000), `out_ready` = 1 → grants alternate 0,1,0,1. Results alternate 0xBF800000 and 0x00000003.
- ftoi 0x4F000000 → `out_ovf` = 1 with macro, 0 without. ftoi 0xCF000000 → `out_y` = 0x80000000, `out_ovf` = 0.
- Hold `out_ready` = 0 for 5 cycles with three requests queued → `out_*` stable, `req_ready` = 0 once S1 fills. After release, all three results appear in order.
- Assert `flush` with S1 and S2 occupied → `out_valid` = 0 next cycle, no accept in the flush cycle, next request has normal 2-cycle latency.
- Drop `rstn` while `out_valid` = 1 → all outputs 0 immediately. After release, the first grant goes to requester 0.
